phase_band_gen: RTL and testbench
=================================

# phase_band_gen

Per-voice oscillator front end that drives the wavetable ROM stage. Holds a phase accumulator advanced on each sample strobe and emits table phase, interpolation fraction, band-limit index and waveform select. Band and waveform changes are applied only at a phase wrap or a retrigger, so the ROM never switches tables mid-cycle. Outputs are registered and feed the ROM's waveform-select, phase and band inputs directly.

## Interface
- ACC_W, 32: phase accumulator / tuning word width
- LUT_BITS, 10: table phase bits output
- FRAC_W, 8: fraction bits below table phase
- NUM_WAVES, 4: waveform count
- NUM_BANDS, 22: band-limited tables per waveform
- BAND_OFFSET, 40: subtracted from raw half-octave index

- clk_i  in  1  system clock
- rst_ni  in  1  asynchronous active-low reset
- sample_tick_i  in  1  one-cycle sample-rate strobe
- inc_i  in  ACC_W  phase increment (tuning word)
- inc_valid_i  in  1  load inc_i
- wave_sel_i  in  $clog2(NUM_WAVES)  requested waveform
- retrig_i  in  1  restart phase at next tick
- phase_o  out  LUT_BITS  acc[ACC_W-1 -: LUT_BITS]
- frac_o  out  FRAC_W  acc[ACC_W-LUT_BITS-1 -: FRAC_W]
- band_o  out  $clog2(NUM_BANDS)  active band index
- wave_o  out  $clog2(NUM_WAVES)  active waveform
- wrap_o  out  1  phase wrapped (or retriggered) this sample
- valid_o  out  1  outputs updated this cycle

## Operation
- inc_q loads inc_i on any cycle with inc_valid_i; no backpressure.
- band_next_q registered one cycle after inc_q changes: p = leading-one position of inc_q; raw = 2*p + inc_q[p-1] (0 for p=0); band_next = clamp(raw - BAND_OFFSET, 0, NUM_BANDS-1). inc_q = 0 gives band_next = 0.
- wave_sel_i sampled continuously into wave_next_q.
- retrig_i sets retrig_pend; cleared when consumed by a tick.
- On sample_tick_i: sum = acc + inc_q (ACC_W+1 bits); carry = sum[ACC_W].
  - retrig_pend or retrig_i: acc <= 0; band_o <= band_next_q; wave_o <= wave_next_q; wrap_o <= 1.
  - else carry: acc <= sum[ACC_W-1:0]; band_o/wave_o take pending values; wrap_o <= 1.
  - else: acc <= sum; band_o/wave_o hold; wrap_o <= 0.
- phase_o/frac_o slice the new acc; valid_o pulses for one cycle.
- Simultaneous inc_valid_i and tick: tick uses old inc_q; new value takes effect next tick.
- No tick: acc and all outputs hold; valid_o = 0, wrap_o = 0.

## Timing
- Tick at cycle T -> phase_o, frac_o, band_o, wave_o, wrap_o, valid_o updated at T+1.
- inc_valid_i at T -> inc_q at T+1 -> band_next_q at T+2; a wrap on a tick at or after T+2 uses the new band.
- retrig_i at T with tick at T: applied on that tick.
- Reset (async assert, any time including mid-sample): acc, inc_q, band_next_q, wave_next_q, retrig_pend, phase_o, frac_o, band_o, wave_o = 0; wrap_o = valid_o = 0. First tick after reset advances from 0 using inc_q = 0 until loaded.
- Ticks are at least 2 cycles apart; back-to-back ticks are still accumulated correctly.

## Structure
- Shared synth package: ACC_W, LUT_BITS, NUM_WAVES, NUM_BANDS, and band/wave index typedefs, shared with the wavetable ROM stage.
- One sub-module: band_select (leading-one detect, half-octave raw index, offset and clamp, registered output).

## Test plan
- inc=0x0040_0000, 1030 ticks -> phase_o 0,1,2…1023,0; wrap_o only on the 1024th tick; frac_o = 0; band_o = 4 after first wrap.
- Band mapping: inc = 1 -> 0; 0x4000_0000 -> 20; 0x6000_0000 -> 21; 0xFFFF_FFFF -> 21 (clamped).
- Band and waveform change mid-cycle: load inc=0x6000_0000 and wave_sel=2 at phase 500 -> band_o/wave_o unchanged until the wrap tick, then 21/2.
- retrig_i pulsed between ticks -> next tick gives phase_o = 0, wrap_o = 1, pending band/wave applied.
- inc_valid_i coincident with tick -> that tick advances by the old increment.
- rst_ni asserted mid-run between tick and output -> all outputs 0 immediately; after release, inc=0 ticks keep phase_o at 0 with valid_o pulsing.

Source files
------------

// File: rtl/phase_band_gen_pkg.sv
// Shared constants and index types for the oscillator front end and the
// wavetable ROM stage that consumes its outputs.
package phase_band_gen_pkg;

    localparam int ACC_W       = 32;
    localparam int LUT_BITS    = 10;
    localparam int FRAC_W      = 8;
    localparam int NUM_WAVES   = 4;
    localparam int NUM_BANDS   = 22;
    localparam int BAND_OFFSET = 40;

    localparam int BAND_W = $clog2(NUM_BANDS);
    localparam int WAVE_W = $clog2(NUM_WAVES);

    typedef logic [ACC_W-1:0]  acc_t;
    typedef logic [BAND_W-1:0] band_t;
    typedef logic [WAVE_W-1:0] wave_t;

    // What a given cycle does to the accumulator and the registered outputs.
    typedef enum logic [1:0] {
        ACT_HOLD    = 2'd0,
        ACT_ADVANCE = 2'd1,
        ACT_WRAP    = 2'd2,
        ACT_RESTART = 2'd3
    } tick_act_e;

endpackage

// File: rtl/phase_band_gen_band_select.sv
// Maps the tuning word to a band-limited table index: leading-one position
// gives the octave, the bit below it splits the octave into halves, then the
// half-octave index is offset and clamped into the table range.
module phase_band_gen_band_select
    import phase_band_gen_pkg::*;
(
    input  logic  i_clk,
    input  logic  i_rst_n,
    input  acc_t  i_inc,
    output band_t o_band
);

    localparam int POS_W = $clog2(ACC_W);
    localparam int RAW_W = POS_W + 1;

    logic [POS_W-1:0] w_pos;
    logic             w_half;
    logic [RAW_W-1:0] w_raw;
    band_t            w_band;
    band_t            r_band;

    // Leading-one detect; the highest set bit wins. Bit 0 alone and an
    // all-zero word both collapse to position 0 with no half step.
    always_comb begin
        w_pos  = '0;
        w_half = 1'b0;
        for (int i = 1; i < ACC_W; i++) begin
            if (i_inc[i]) begin
                w_pos  = POS_W'(i);
                w_half = i_inc[i-1];
            end
        end
    end

    assign w_raw = {w_pos, w_half};

    // Offset and clamp the half-octave index into [0, NUM_BANDS-1].
    always_comb begin
        w_band = '0;
        if (w_raw < RAW_W'(BAND_OFFSET)) begin
            w_band = '0;
        end else if ((w_raw - RAW_W'(BAND_OFFSET)) > RAW_W'(NUM_BANDS - 1)) begin
            w_band = band_t'(NUM_BANDS - 1);
        end else begin
            w_band = band_t'(w_raw - RAW_W'(BAND_OFFSET));
        end
    end

    // Registered so the band decision lags the tuning word by one cycle.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_band <= '0;
        end else begin
            r_band <= w_band;
        end
    end

    assign o_band = r_band;

endmodule

// File: rtl/phase_band_gen.sv
// Per-voice phase accumulator feeding the wavetable ROM. Band and waveform
// only change on a phase wrap or a retrigger so the ROM never switches
// tables in the middle of a cycle.
module phase_band_gen
    import phase_band_gen_pkg::*;
(
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                sample_tick_i,
    input  logic [ACC_W-1:0]    inc_i,
    input  logic                inc_valid_i,
    input  logic [WAVE_W-1:0]   wave_sel_i,
    input  logic                retrig_i,
    output logic [LUT_BITS-1:0] phase_o,
    output logic [FRAC_W-1:0]   frac_o,
    output logic [BAND_W-1:0]   band_o,
    output logic [WAVE_W-1:0]   wave_o,
    output logic                wrap_o,
    output logic                valid_o
);

    acc_t       r_acc;
    acc_t       r_inc;
    wave_t      r_wave_next;
    logic       r_retrig_pend;
    band_t      r_band;
    wave_t      r_wave;
    logic       r_wrap;
    logic       r_valid;

    band_t      w_band_next;
    logic [ACC_W:0] w_sum;
    logic       w_restart;
    tick_act_e  w_act;

    phase_band_gen_band_select u_band_select (
        .i_clk   (clk_i),
        .i_rst_n (rst_ni),
        .i_inc   (r_inc),
        .o_band  (w_band_next)
    );

    // Tuning word, requested waveform and retrigger request capture.
    // A tick consumes a pending retrigger whether it came early or with
    // the tick itself.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_inc         <= '0;
            r_wave_next   <= '0;
            r_retrig_pend <= 1'b0;
        end else begin
            if (inc_valid_i) begin
                r_inc <= inc_i;
            end
            r_wave_next <= wave_sel_i;
            if (sample_tick_i) begin
                r_retrig_pend <= 1'b0;
            end else if (retrig_i) begin
                r_retrig_pend <= 1'b1;
            end
        end
    end

    // Decide what this cycle does; retrigger beats a natural wrap.
    always_comb begin
        w_act     = ACT_HOLD;
        w_sum     = {1'b0, r_acc} + {1'b0, r_inc};
        w_restart = r_retrig_pend | retrig_i;
        if (sample_tick_i) begin
            if (w_restart) begin
                w_act = ACT_RESTART;
            end else if (w_sum[ACC_W]) begin
                w_act = ACT_WRAP;
            end else begin
                w_act = ACT_ADVANCE;
            end
        end
    end

    // Accumulator and registered outputs; wrap/valid are single-cycle pulses.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_acc   <= '0;
            r_band  <= '0;
            r_wave  <= '0;
            r_wrap  <= 1'b0;
            r_valid <= 1'b0;
        end else begin
            case (w_act)
                ACT_RESTART: begin
                    r_acc   <= '0;
                    r_band  <= w_band_next;
                    r_wave  <= r_wave_next;
                    r_wrap  <= 1'b1;
                    r_valid <= 1'b1;
                end
                ACT_WRAP: begin
                    r_acc   <= w_sum[ACC_W-1:0];
                    r_band  <= w_band_next;
                    r_wave  <= r_wave_next;
                    r_wrap  <= 1'b1;
                    r_valid <= 1'b1;
                end
                ACT_ADVANCE: begin
                    r_acc   <= w_sum[ACC_W-1:0];
                    r_wrap  <= 1'b0;
                    r_valid <= 1'b1;
                end
                default: begin
                    r_wrap  <= 1'b0;
                    r_valid <= 1'b0;
                end
            endcase
        end
    end

    assign phase_o = r_acc[ACC_W-1 -: LUT_BITS];
    assign frac_o  = r_acc[ACC_W-LUT_BITS-1 -: FRAC_W];
    assign band_o  = r_band;
    assign wave_o  = r_wave;
    assign wrap_o  = r_wrap;
    assign valid_o = r_valid;

endmodule

// File: tb/tb_phase_band_gen.sv
// Bench for phase_band_gen: a plain-arithmetic reference model checked every
// cycle, plus directed scenarios with hand-computed expectations.
module tb_phase_band_gen;
    import phase_band_gen_pkg::*;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        sample_tick_i = 1'b0;
    logic [31:0] inc_i = '0;
    logic        inc_valid_i = 1'b0;
    logic [1:0]  wave_sel_i = '0;
    logic        retrig_i = 1'b0;
    logic [9:0]  phase_o;
    logic [7:0]  frac_o;
    logic [4:0]  band_o;
    logic [1:0]  wave_o;
    logic        wrap_o;
    logic        valid_o;

    int checks = 0;
    int failures = 0;

    phase_band_gen dut (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .sample_tick_i (sample_tick_i),
        .inc_i         (inc_i),
        .inc_valid_i   (inc_valid_i),
        .wave_sel_i    (wave_sel_i),
        .retrig_i      (retrig_i),
        .phase_o       (phase_o),
        .frac_o        (frac_o),
        .band_o        (band_o),
        .wave_o        (wave_o),
        .wrap_o        (wrap_o),
        .valid_o       (valid_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
        end
    endtask

    // Band index straight from the arithmetic definition.
    function automatic int band_of(input logic [31:0] v);
        int p;
        int raw;
        logic [31:0] t;
        if (v == 32'd0) return 0;
        p = 0;
        t = v;
        while (t > 32'd1) begin
            t = t >> 1;
            p++;
        end
        raw = 2 * p + ((p > 0) ? int'(v[p-1]) : 0) - 40;
        if (raw < 0) return 0;
        if (raw > 21) return 21;
        return raw;
    endfunction

    // Reference model state.
    logic [31:0] m_acc = '0;
    logic [31:0] m_inc = '0;
    logic [32:0] m_sum;
    int          m_bn = 0;
    logic [1:0]  m_wn = '0;
    bit          m_pend = 1'b0;
    int          m_band = 0;
    logic [1:0]  m_wave = '0;
    bit          m_wrap = 1'b0;
    bit          m_valid = 1'b0;

    always @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            m_acc = '0; m_inc = '0; m_bn = 0; m_wn = '0; m_pend = 1'b0;
            m_band = 0; m_wave = '0; m_wrap = 1'b0; m_valid = 1'b0;
        end else begin
            if (sample_tick_i) begin
                m_sum = {1'b0, m_acc} + {1'b0, m_inc};
                if (m_pend || retrig_i) begin
                    m_acc = '0; m_band = m_bn; m_wave = m_wn; m_wrap = 1'b1;
                end else if (m_sum[32]) begin
                    m_acc = m_sum[31:0]; m_band = m_bn; m_wave = m_wn; m_wrap = 1'b1;
                end else begin
                    m_acc = m_sum[31:0]; m_wrap = 1'b0;
                end
                m_valid = 1'b1;
                m_pend = 1'b0;
            end else begin
                m_wrap = 1'b0;
                m_valid = 1'b0;
                if (retrig_i) m_pend = 1'b1;
            end
            m_bn = band_of(m_inc);
            if (inc_valid_i) m_inc = inc_i;
            m_wn = wave_sel_i;
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk_i) begin
        if (rst_ni) begin
            chk("model_outputs",
                64'({phase_o, frac_o, band_o, wave_o, wrap_o, valid_o}),
                64'({m_acc[31:22], m_acc[21:14], 5'(m_band), m_wave, m_wrap, m_valid}));
        end
    end

    logic [1:0] cur_wave = '0;

    task automatic do_cycle(input bit tick, input bit rt, input bit iv, input logic [31:0] inc);
        @(negedge clk_i);
        sample_tick_i = tick;
        retrig_i      = rt;
        inc_valid_i   = iv;
        inc_i         = inc;
        wave_sel_i    = cur_wave;
        @(posedge clk_i);
        #1;
        sample_tick_i = 1'b0;
        retrig_i      = 1'b0;
        inc_valid_i   = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) do_cycle(1'b0, 1'b0, 1'b0, 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] band_inc [4];
        int          band_exp [4];
        int          wraps;
        int          gap;
        bit          t;
        logic [31:0] rinc;

        // Reset state
        repeat (3) @(posedge clk_i);
        #1;
        chk("reset_outputs", 64'({phase_o, frac_o, band_o, wave_o, wrap_o, valid_o}), 64'd0);
        @(negedge clk_i);
        rst_ni = 1'b1;

        // Ramp: 0x0040_0000 steps one table entry per tick
        do_cycle(1'b0, 1'b0, 1'b1, 32'h0040_0000);
        idle(2);
        wraps = 0;
        for (int k = 1; k <= 1030; k++) begin
            do_cycle(1'b1, 1'b0, 1'b0, 32'd0);
            if (wrap_o) wraps++;
            chk("ramp", 64'({phase_o, frac_o, band_o, wrap_o, valid_o}),
                64'({10'(k % 1024), 8'd0, 5'((k >= 1024) ? 4 : 0), (k == 1024), 1'b1}));
            idle(1);
        end
        chk("ramp_wrap_count", 64'(wraps), 64'd1);

        // Band mapping via retrigger
        band_inc[0] = 32'h0000_0001; band_exp[0] = 0;
        band_inc[1] = 32'h4000_0000; band_exp[1] = 20;
        band_inc[2] = 32'h6000_0000; band_exp[2] = 21;
        band_inc[3] = 32'hFFFF_FFFF; band_exp[3] = 21;
        for (int i = 0; i < 4; i++) begin
            do_cycle(1'b0, 1'b0, 1'b1, band_inc[i]);
            idle(2);
            do_cycle(1'b1, 1'b1, 1'b0, 32'd0);
            chk("band_map", 64'({band_o, phase_o, wrap_o}), 64'({5'(band_exp[i]), 10'd0, 1'b1}));
            idle(1);
        end

        // Band/wave change mid-cycle waits for the wrap
        cur_wave = 2'd0;
        do_cycle(1'b0, 1'b0, 1'b1, 32'h0040_0000);
        idle(2);
        do_cycle(1'b1, 1'b1, 1'b0, 32'd0);
        chk("midcyc_start", 64'({phase_o, band_o, wave_o}), 64'({10'd0, 5'd4, 2'd0}));
        idle(1);
        for (int k = 0; k < 500; k++) begin
            do_cycle(1'b1, 1'b0, 1'b0, 32'd0);
            idle(1);
        end
        chk("midcyc_phase500", 64'(phase_o), 64'd500);
        cur_wave = 2'd2;
        do_cycle(1'b0, 1'b0, 1'b1, 32'h6000_0000);
        idle(1);
        do_cycle(1'b1, 1'b0, 1'b0, 32'd0);
        chk("midcyc_hold", 64'({phase_o, band_o, wave_o, wrap_o}), 64'({10'd884, 5'd4, 2'd0, 1'b0}));
        idle(1);
        do_cycle(1'b1, 1'b0, 1'b0, 32'd0);
        chk("midcyc_wrap", 64'({phase_o, band_o, wave_o, wrap_o}), 64'({10'd244, 5'd21, 2'd2, 1'b1}));
        idle(1);

        // Retrigger between ticks
        cur_wave = 2'd1;
        do_cycle(1'b0, 1'b0, 1'b1, 32'h0040_0000);
        idle(2);
        do_cycle(1'b0, 1'b1, 1'b0, 32'd0);
        idle(1);
        do_cycle(1'b1, 1'b0, 1'b0, 32'd0);
        chk("retrig", 64'({phase_o, frac_o, band_o, wave_o, wrap_o, valid_o}),
            64'({10'd0, 8'd0, 5'd4, 2'd1, 1'b1, 1'b1}));
        idle(1);

        // Increment load coincident with tick uses the old increment
        do_cycle(1'b1, 1'b0, 1'b1, 32'h0080_0000);
        chk("inc_coincident_old", 64'(phase_o), 64'd1);
        idle(1);
        do_cycle(1'b1, 1'b0, 1'b0, 32'd0);
        chk("inc_coincident_new", 64'(phase_o), 64'd3);
        idle(1);

        // Reset asserted mid-sample
        @(negedge clk_i);
        sample_tick_i = 1'b1;
        #2;
        rst_ni = 1'b0;
        #1;
        chk("midrun_reset", 64'({phase_o, frac_o, band_o, wave_o, wrap_o, valid_o}), 64'd0);
        sample_tick_i = 1'b0;
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        rst_ni = 1'b1;
        cur_wave = 2'd0;
        for (int k = 0; k < 3; k++) begin
            do_cycle(1'b1, 1'b0, 1'b0, 32'd0);
            chk("post_reset_tick", 64'({phase_o, frac_o, valid_o, wrap_o}), 64'({10'd0, 8'd0, 1'b1, 1'b0}));
            do_cycle(1'b0, 1'b0, 1'b0, 32'd0);
            chk("post_reset_idle", 64'({phase_o, valid_o}), 64'({10'd0, 1'b0}));
        end

        // Randomized traffic, checked by the model every cycle
        gap = 2;
        for (int n = 0; n < 3000; n++) begin
            t = ((gap >= 1) && ($urandom_range(0, 2) == 0)) || ($urandom_range(0, 49) == 0);
            case ($urandom_range(0, 3))
                0: rinc = $urandom;
                1: rinc = $urandom >> $urandom_range(0, 31);
                2: rinc = 32'hFFFF_FFFF;
                default: rinc = $urandom >> 4;
            endcase
            if ($urandom_range(0, 19) == 0) cur_wave = 2'($urandom_range(0, 3));
            do_cycle(t, ($urandom_range(0, 29) == 0), ($urandom_range(0, 9) == 0), rinc);
            gap = t ? 0 : gap + 1;
        end
        idle(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
